// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Packed ALU word layout, condition encodings and flag struct.
package alu_writeback_stage_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 3;
    localparam int PKT_W  = 20;

    localparam int POS_S = 16;
    localparam int POS_V = 17;
    localparam int POS_Z = 18;
    localparam int POS_C = 19;

    localparam logic [2:0] COND_BE  = 3'd0;
    localparam logic [2:0] COND_BLT = 3'd1;
    localparam logic [2:0] COND_BLE = 3'd2;
    localparam logic [2:0] COND_BNE = 3'd3;
    localparam logic [2:0] COND_AL  = 3'd4;
    localparam logic [2:0] COND_NV  = 3'd5;
    localparam logic [2:0] COND_BCS = 3'd6;
    localparam logic [2:0] COND_BCC = 3'd7;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic s;
    } flags_t;

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic [RD_W-1:0]  rd;
        logic             we;
        logic             setf;
        logic             br;
        logic [2:0]       cond;
    } wb_ent_t;

    function automatic flags_t pkt_flags(input logic [PKT_W-1:0] p);
        flags_t f;
        f.c = p[POS_C];
        f.z = p[POS_Z];
        f.v = p[POS_V];
        f.s = p[POS_S];
        return f;
    endfunction

endpackage

// File: rtl/wb_cond_eval.sv
// Branch condition evaluator: maps a condition code and the
// committed flags to a taken/not-taken decision.
module wb_cond_eval
    import alu_writeback_stage_pkg::*;
(
    input  logic [2:0] i_cond,
    input  flags_t     i_flags,
    output logic       o_taken
);

    logic w_lt;

    assign w_lt = i_flags.s ^ i_flags.v;

    always_comb begin
        o_taken = 1'b0;
        unique case (i_cond)
            COND_BE:  o_taken = i_flags.z;
            COND_BLT: o_taken = w_lt;
            COND_BLE: o_taken = i_flags.z | w_lt;
            COND_BNE: o_taken = ~i_flags.z;
            COND_AL:  o_taken = 1'b1;
            COND_NV:  o_taken = 1'b0;
            COND_BCS: o_taken = i_flags.c;
            COND_BCC: o_taken = ~i_flags.c;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage: two-entry skid buffer feeding the register file,
// architectural flag register and registered branch resolution.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  in_pkt,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic              in_setf,
    input  logic              in_br,
    input  logic [2:0]        in_cond,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic [3:0]        flags_q,
    output logic              br_valid,
    output logic              br_taken
);

    wb_ent_t r_h;
    wb_ent_t r_k;
    logic    r_h_vld;
    logic    r_k_vld;
    logic    r_in_ready;
    flags_t  r_flags;
    logic    r_br_valid;
    logic    r_br_taken;

    wb_ent_t w_in;
    logic    w_acc;
    logic    w_xfer;
    logic    w_taken;

    assign w_in.pkt  = in_pkt;
    assign w_in.rd   = in_rd;
    assign w_in.we   = in_we;
    assign w_in.setf = in_setf;
    assign w_in.br   = in_br;
    assign w_in.cond = in_cond;

    assign w_acc  = in_valid & r_in_ready;
    assign w_xfer = r_h_vld & out_ready;

    // Branches see flags committed by every older packet.
    wb_cond_eval u_cond (
        .i_cond  (r_h.cond),
        .i_flags (r_flags),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h        <= '0;
            r_k        <= '0;
            r_h_vld    <= 1'b0;
            r_k_vld    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (w_xfer) begin
            if (r_k_vld) begin
                r_h        <= r_k;
                r_k_vld    <= 1'b0;
                r_in_ready <= 1'b1;
            end else if (w_acc) begin
                r_h <= w_in;
            end else begin
                r_h_vld <= 1'b0;
            end
        end else if (w_acc) begin
            if (!r_h_vld) begin
                r_h     <= w_in;
                r_h_vld <= 1'b1;
            end else begin
                r_k        <= w_in;
                r_k_vld    <= 1'b1;
                r_in_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags    <= '0;
            r_br_valid <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_br_valid <= 1'b0;
            if (w_xfer && r_h.br) begin
                r_br_valid <= 1'b1;
                r_br_taken <= w_taken;
            end else if (w_xfer && r_h.setf) begin
                r_flags <= pkt_flags(r_h.pkt);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_h_vld;
    assign wb_data   = r_h.pkt[DATA_W-1:0];
    assign wb_rd     = r_h.rd;
    assign wb_we     = r_h_vld & r_h.we & ~r_h.br;
    assign flags_q   = r_flags;
    assign br_valid  = r_br_valid;
    assign br_taken  = r_br_taken;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: data order, flags,
// branch outcomes, backpressure and asynchronous reset.
module tb_alu_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_pkt;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        in_setf;
    logic        in_br;
    logic [2:0]  in_cond;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        wb_we;
    logic [3:0]  flags_q;
    logic        br_valid;
    logic        br_taken;

    alu_writeback_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pkt    (in_pkt),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .in_setf   (in_setf),
        .in_br     (in_br),
        .in_cond   (in_cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_we     (wb_we),
        .flags_q   (flags_q),
        .br_valid  (br_valid),
        .br_taken  (br_taken)
    );

    typedef struct {
        logic [15:0] d;
        logic [2:0]  rd;
        logic        we;
        logic        setf;
        logic        br;
        logic        taken;
        logic [3:0]  fl;
    } sb_t;

    sb_t        q[$];
    sb_t        e_pop;
    sb_t        e_push;
    logic [3:0] m_flags;
    logic [3:0] p_flags;
    logic       pend_br;
    logic       exp_tk;
    bit         rnd_bp;
    int         n_cmp;
    int         n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // f = {C,Z,V,S}
    function automatic logic ref_cond(input logic [2:0] c,
                                      input logic [3:0] f);
        case (c)
            3'd0: return f[2];
            3'd1: return f[0] != f[1];
            3'd2: return f[2] || (f[0] != f[1]);
            3'd3: return !f[2];
            3'd4: return 1'b1;
            3'd5: return 1'b0;
            3'd6: return f[3];
            default: return !f[3];
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_flags = 4'h0;
            p_flags = 4'h0;
            pend_br = 1'b0;
        end else begin
            check("flags", flags_q, m_flags);
            if (pend_br) begin
                check("br_valid", br_valid, 1);
                check("br_taken", br_taken, exp_tk);
                pend_br = 1'b0;
            end else begin
                check("br_idle", br_valid, 0);
            end
            if (!out_valid) check("we_idle", wb_we, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 0, 1);
                end else begin
                    e_pop = q.pop_front();
                    check("wb_data", wb_data, e_pop.d);
                    check("wb_rd", wb_rd, e_pop.rd);
                    check("wb_we", wb_we, e_pop.we && !e_pop.br);
                    if (e_pop.br) begin
                        pend_br = 1'b1;
                        exp_tk  = e_pop.taken;
                    end else if (e_pop.setf) begin
                        m_flags = e_pop.fl;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e_push.d     = in_pkt[15:0];
                e_push.rd    = in_rd;
                e_push.we    = in_we;
                e_push.setf  = in_setf;
                e_push.br    = in_br;
                e_push.fl    = in_pkt[19:16];
                e_push.taken = 1'b0;
                if (in_br)
                    e_push.taken = ref_cond(in_cond, p_flags);
                else if (in_setf)
                    p_flags = in_pkt[19:16];
                q.push_back(e_push);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [19:0] p, input logic [2:0] rd,
                        input logic we, input logic setf,
                        input logic br, input logic [2:0] cond);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_pkt   = p;
        in_rd    = rd;
        in_we    = we;
        in_setf  = setf;
        in_br    = br;
        in_cond  = cond;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || pend_br || out_valid) && n < 1000) begin
            tick();
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
        tick();
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rnd_bp    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pkt    = '0;
        in_rd     = '0;
        in_we     = 1'b0;
        in_setf   = 1'b0;
        in_br     = 1'b0;
        in_cond   = '0;
        out_ready = 1'b0;
        m_flags   = 4'h0;
        p_flags   = 4'h0;
        pend_br   = 1'b0;
        exp_tk    = 1'b0;

        @(negedge clk);
        check("rst_ovalid", out_valid, 0);
        check("rst_iready", in_ready, 1);
        check("rst_flags", flags_q, 0);
        check("rst_data", wb_data, 0);
        check("rst_rd", wb_rd, 0);
        check("rst_we", wb_we, 0);
        check("rst_brv", br_valid, 0);
        check("rst_brt", br_taken, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send({4'h0, 16'h1000 + 16'(i * 17)}, 3'(i + 1),
                 1'b1, 1'b0, 1'b0, 3'd0);
            check("lat_ovalid", out_valid, 1);
            check("stream_rdy", in_ready, 1);
        end
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        send(20'h0_AAAA, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
        check("bp_rdy1", in_ready, 1);
        send(20'h0_BBBB, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        check("bp_rdy0", in_ready, 0);
        in_valid = 1'b1;
        in_pkt   = 20'h0_CCCC;
        in_rd    = 3'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_hold", in_ready, 0);
            check("bp_head", wb_data, 16'hAAAA);
        end
        out_ready = 1'b1;
        send(20'h0_CCCC, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0);
        wait_idle();

        // Flag commit
        send(20'h4_0000, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0);
        send(20'hF_FFFF, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0);
        wait_idle();
        check("flag_z", flags_q, 4'b0100);

        // Branch right after a flag-setting packet
        send(20'h1_0000, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0);
        send(20'h0_0000, 3'd6, 1'b1, 1'b1, 1'b1, 3'd1);
        send(20'h0_0000, 3'd7, 1'b1, 1'b1, 1'b1, 3'd0);
        wait_idle();
        check("flag_s", flags_q, 4'b0001);

        // Condition sweep under random backpressure
        rnd_bp = 1'b1;
        for (int f = 0; f < 16; f++) begin
            send({4'(f), 16'(f)}, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0);
            for (int c = 0; c < 8; c++)
                send(20'h0_0000, 3'(c), 1'b1, 1'b0, 1'b1, 3'(c));
        end
        wait_idle();
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        check("sweep_flags", flags_q, 4'hF);

        // Reset with both entries full
        out_ready = 1'b0;
        send(20'h0_1111, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0);
        send(20'h0_2222, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0);
        check("pre_rst_full", in_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_ovalid", out_valid, 0);
        check("mrst_iready", in_ready, 1);
        check("mrst_flags", flags_q, 0);
        check("mrst_we", wb_we, 0);
        check("mrst_brv", br_valid, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send(20'h2_5A5A, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0);
        send(20'h0_0000, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3);
        wait_idle();
        check("post_rst_flags", flags_q, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Stage directly downstream of the combinational ALU. It accepts the packed 20-bit ALU result word and holds it in a two-entry skid buffer under a valid/ready handshake. On in-order retirement it drives the register-file write port, updates the architectural S/V/Z/C flag register, and evaluates conditional-branch outcomes against the committed flags.

Parameters:
DATA_W, 16, result data width
RD_W, 3, destination register index width (8 GPRs)
PKT_W, 20, packed ALU word width: [15:0] result, [16] S, [17] V, [18] Z, [19] C

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  stage can accept a word
in_pkt  in  PKT_W  packed ALU result {C,Z,V,S,data}
in_rd  in  RD_W  destination register
in_we  in  1  write result to in_rd
in_setf  in  1  commit packet flags to flag register
in_br  in  1  packet is a conditional branch (no write, no flag update)
in_cond  in  3  branch condition code
out_valid  out  1  head entry valid toward register file
out_ready  in  1  register file accepts head entry
wb_data  out  DATA_W  head result
wb_rd  out  RD_W  head destination
wb_we  out  1  head write enable (qualified by out_valid)
flags_q  out  4  committed flags {C,Z,V,S}
br_valid  out  1  one-cycle pulse: branch outcome available
br_taken  out  1  branch outcome, held until next br_valid

Behaviour:
- Reset (async, rst_n=0): both entry valids=0, out_valid=0, in_ready=1, flags_q=4'b0000, br_valid=0, br_taken=0, wb_data=0, wb_rd=0, wb_we=0. Reset mid-transfer discards buffered entries; no flag or branch effect.
- Buffer: head (H) and skid (K) entries hold {pkt, rd, we, setf, br, cond}. Outputs are driven from H only; unpacking follows the PKT_W layout.
- in_ready = !K.valid, registered so it is not combinationally dependent on out_ready.
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Same-edge cases:
  - accept, H empty → H.
  - accept, H full, no transfer → K.
  - accept + transfer, K empty → H replaced by new word.
  - accept + transfer, K full → impossible, since in_ready=0.
  - transfer only → K moves to H if valid, else H empties.
- Throughput: one word per cycle while out_ready=1. Latency from accept to out_valid is 1 cycle.
- Ordering: strict FIFO.
- Flags: on transfer with setf=1 and br=0, flags_q <= {C,Z,V,S} of H, visible the next cycle. Otherwise flags_q holds.
- Branch: on transfer with br=1, evaluate cond against the current flags_q, i.e. flags committed by all older packets. Register the outcome: br_taken valid and br_valid=1 on the following cycle; br_valid is 1 for exactly one cycle.
- Branch packets: wb_we is forced to 0 and flags are not touched, regardless of we/setf.
- Condition codes:
  - 0 BE: Z
  - 1 BLT: S^V
  - 2 BLE: Z|(S^V)
  - 3 BNE: !Z
  - 4 always: 1
  - 5 never: 0
  - 6 BCS: C
  - 7 BCC: !C
- wb_we = out_valid && H.we && !H.br.
- Back-to-back case: packet with setf directly followed by a branch. The branch sees the updated flags, because the flag commit happens on the same edge the branch becomes head.
- No arithmetic is performed in this block; widths pass through unchanged.

Decomposition:
- Shared package: PKT_W field positions (S=16, V=17, Z=18, C=19), the COND_* encodings 0..7, and a flags struct {c,z,v,s}.
- One sub-module, wb_cond_eval: a combinational function from (cond, flags) to taken. It is reused by the branch unit.
- The skid buffer stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-stream with H and K full → next cycle out_valid=0, in_ready=1, flags_q=0, no wb_we, no br_valid.
- Streaming: 4 words accepted back-to-back with out_ready=1 → wb_data equals each data word in order, 1-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 → 2 words buffered, in_ready=0 from the 3rd cycle; release → both drain in order with no loss or duplication.
- Flag commit: in_pkt=20'h4_0000 (Z=1, data 0), setf=1 → flags_q=4'b0100 after transfer. A following word with setf=0 and pkt=20'hF_FFFF → flags_q unchanged.
- Branch after flags: setf packet with S=1, V=0, then br cond=1 (BLT) → br_valid pulse with br_taken=1. Repeat with cond=0 (BE) → br_taken=0. wb_we=0 for both branch packets.
- Condition sweep: for each of the 16 flag values, branch with conds 0..7 → br_taken matches the table. cond=4 always 1, cond=5 always 0.
